quat_result_serializer: RTL and testbench

Downstream stage of the pipelined direct quaternion multiplier. It captures each product quaternion (four signed 32-bit components r1..r4) when the multiplier's result-valid strobe fires. Captured quaternions are buffered in a small FIFO and streamed out one 32-bit component per beat over a valid/ready interface, so a narrow consumer such as a bus bridge or UART framer can drain results at its own pace. Results that arrive while the buffer is full are dropped and flagged.

---
 rtl/quat_result_serializer_if.sv | 30 +++
 rtl/quat_result_serializer.sv | 112 +++++++++++
 tb/tb_quat_result_serializer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quat_result_serializer_if.sv
// Handshake bundle between the quaternion multiplier, the serializer and
// the narrow downstream consumer: a four-component input side and a
// one-component-per-beat output side.
interface quat_result_serializer_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_r1;
  logic [W-1:0] in_r2;
  logic [W-1:0] in_r3;
  logic [W-1:0] in_r4;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;
  logic         out_last;

  // Producer of quaternions and consumer of beats (multiplier side + sink).
  modport master (
    output in_valid, in_r1, in_r2, in_r3, in_r4, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  // The serializer itself.
  modport slave (
    input  in_valid, in_r1, in_r2, in_r3, in_r4, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/quat_result_serializer.sv
// Captures product quaternions into a small FIFO and streams them out one
// component per beat (r1, r2, r3, r4) over a valid/ready interface.
// Quaternions offered while the FIFO is full are dropped and flagged.
module quat_result_serializer #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  quat_result_serializer_if.slave  bus,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     drop_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                 state, state_next;
  logic [1:0]             idx, idx_next;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [OW-1:0]          occ_next;
  logic [3:0][W-1:0]      mem [DEPTH];
  logic                   push, pop, beat;

  // in_ready looks only at registered occupancy, so a full FIFO never
  // accepts in the same cycle it pops.
  assign bus.in_ready = !rst && (occupancy < FULL);

  assign push = bus.in_valid && bus.in_ready;
  assign beat = (state == STREAM) && bus.out_ready;
  assign pop  = beat && (idx == 2'd3);

  // Occupancy after this cycle's push/pop; simultaneous push+pop cancels.
  always_comb begin
    occ_next = occupancy;
    case ({push, pop})
      2'b10:   occ_next = occupancy + OW'(1);
      2'b01:   occ_next = occupancy - OW'(1);
      default: occ_next = occupancy;
    endcase
  end

  // Serializer next-state and beat outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_next    = state;
    idx_next      = idx;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_idx   = 2'd0;
    bus.out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (occupancy != '0) begin
          state_next = STREAM;
          idx_next   = 2'd0;
        end
      end
      STREAM: begin
        bus.out_valid = 1'b1;
        bus.out_data  = mem[rd_ptr][idx];
        bus.out_idx   = idx;
        bus.out_last  = (idx == 2'd3);
        if (bus.out_ready) begin
          idx_next = idx + 2'd1;
          if (idx == 2'd3 && occ_next == '0) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state: FSM, beat index, pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      occupancy <= occ_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (bus.in_valid && !bus.in_ready) drop_err <= 1'b1;
    end
  end

  // Quaternion storage, one whole quaternion per slot.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy and the
    // pointers decide what is valid, and outputs are gated to zero when idle.
    if (push) begin
      mem[wr_ptr] <= {bus.in_r4, bus.in_r3, bus.in_r2, bus.in_r1};
    end
  end

endmodule

// File: tb/tb_quat_result_serializer.sv
// Directed, self-checking bench for quat_result_serializer (DEPTH=2, W=32).
module tb_quat_result_serializer;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] r3;
    logic [31:0] r4;
  } quat_t;

  typedef struct {
    logic        push;
    logic        rdy;
    logic        v;
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [1:0]  occ;
  logic        drop_err;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_q[$];
  vec_t        vq[$];

  quat_result_serializer_if #(.W(32)) bus();

  quat_result_serializer #(.DEPTH(2), .W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .occupancy (occ),
    .drop_err  (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic quat_t gen_q(input int n);
    quat_t q;
    q.r1 = 32'(n);
    q.r2 = 32'(-n);
    q.r3 = 32'(n) << 16;
    q.r4 = ~32'(n);
    return q;
  endfunction

  function automatic logic [31:0] word(input quat_t q, input int i);
    case (i)
      0:       return q.r1;
      1:       return q.r2;
      2:       return q.r3;
      default: return q.r4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_q(input quat_t q);
    bus.in_r1 = q.r1;
    bus.in_r2 = q.r2;
    bus.in_r3 = q.r3;
    bus.in_r4 = q.r4;
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic push, input logic rdy, input logic v, input logic [31:0] data,
                     input logic [1:0] idx, input logic last, input logic [1:0] o, input logic ir);
    vec_t t;
    t.push = push; t.rdy = rdy; t.v = v; t.data = data;
    t.idx = idx; t.last = last; t.occ = o; t.ir = ir;
    vq.push_back(t);
  endtask

  // Streams until exp_beats beats are seen, optionally pushing n_new fresh
  // quaternions gen_q(first_n..) whenever in_ready is high. exp_q must already
  // hold the words of entries that are in the FIFO at entry.
  task automatic run_stream(input int n_new, input int first_n, input bit rand_rdy, input int exp_beats);
    int          pushed = 0;
    int          beats = 0;
    quat_t       q;
    logic [31:0] want;
    for (int cyc = 0; cyc < 2000 && beats < exp_beats; cyc++) begin
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pushed < n_new && bus.in_ready) begin
        q = gen_q(first_n + pushed);
        drive_q(q);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(word(q, k));
        pushed++;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check($sformatf("beat%0d.data", beats), bus.out_data, want);
        check($sformatf("beat%0d.idx", beats), 32'(bus.out_idx), 32'(beats % 4));
        check($sformatf("beat%0d.last", beats), 32'(bus.out_last), 32'(beats % 4 == 3));
        beats++;
      end
      step_edge();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream.beats", beats, exp_beats);
    check("stream.leftover", exp_q.size(), 0);
  endtask

  initial begin
    quat_t qt, qa, qb;
    int    hs;
    n_cmp = 0;
    n_err = 0;
    hs    = 0;
    qt = '{r1: 32'h0000_0005, r2: 32'hFFFF_FFFE, r3: 32'h7FFF_FFFF, r4: 32'h8000_0000};

    // Single push with sink always ready, then the same quaternion under backpressure.
    add(1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 1, 32'h0000_0005, 0, 0, 1, 1);
    add(0, 1, 1, 32'hFFFF_FFFE, 1, 0, 1, 1);
    add(0, 1, 1, 32'h7FFF_FFFF, 2, 0, 1, 1);
    add(0, 1, 1, 32'h8000_0000, 3, 1, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 1, 32'h0000_0005, 0, 0, 1, 1);
    add(0, 0, 1, 32'hFFFF_FFFE, 1, 0, 1, 1);
    add(0, 0, 1, 32'hFFFF_FFFE, 1, 0, 1, 1);
    add(0, 1, 1, 32'hFFFF_FFFE, 1, 0, 1, 1);
    add(0, 0, 1, 32'h7FFF_FFFF, 2, 0, 1, 1);
    add(0, 1, 1, 32'h7FFF_FFFF, 2, 0, 1, 1);
    add(0, 1, 1, 32'h8000_0000, 3, 1, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_q('0);
    step_edge();
    step_edge();
    @(negedge clk);
    check("rst.out_valid", 32'(bus.out_valid), 0);
    check("rst.out_data", bus.out_data, 0);
    check("rst.out_idx", 32'(bus.out_idx), 0);
    check("rst.out_last", 32'(bus.out_last), 0);
    check("rst.occupancy", 32'(occ), 0);
    check("rst.drop_err", 32'(drop_err), 0);
    check("rst.in_ready", 32'(bus.in_ready), 0);
    step_edge();
    rst = 1'b0;
    @(negedge clk);
    check("release.in_ready", 32'(bus.in_ready), 1);
    step_edge();

    // Table-driven single push and backpressure.
    foreach (vq[i]) begin
      bus.in_valid  = vq[i].push;
      if (vq[i].push) drive_q(qt);
      bus.out_ready = vq[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vq[i].v));
      if (vq[i].v) begin
        check($sformatf("vec%0d.out_data", i), bus.out_data, vq[i].data);
        check($sformatf("vec%0d.out_idx", i), 32'(bus.out_idx), 32'(vq[i].idx));
        check($sformatf("vec%0d.out_last", i), 32'(bus.out_last), 32'(vq[i].last));
        if (bus.out_ready) hs++;
      end
      check($sformatf("vec%0d.occupancy", i), 32'(occ), 32'(vq[i].occ));
      check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vq[i].ir));
      step_edge();
    end
    bus.in_valid = 1'b0;
    check("vec.handshakes", hs, 8);

    // Push coinciding with the idx-3 pop of the only held entry.
    qa = gen_q(200);
    qb = gen_q(201);
    bus.in_valid = 1'b1; drive_q(qa); bus.out_ready = 1'b0;
    step_edge();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step_edge();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("pp.a%0d.data", k), bus.out_data, word(qa, k));
      check($sformatf("pp.a%0d.idx", k), 32'(bus.out_idx), 32'(k));
      step_edge();
    end
    bus.in_valid = 1'b1; drive_q(qb);
    @(negedge clk);
    check("pp.a3.idx", 32'(bus.out_idx), 3);
    check("pp.a3.last", 32'(bus.out_last), 1);
    check("pp.a3.in_ready", 32'(bus.in_ready), 1);
    check("pp.a3.occupancy", 32'(occ), 1);
    step_edge();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    check("pp.b0.out_valid", 32'(bus.out_valid), 1);
    check("pp.b0.idx", 32'(bus.out_idx), 0);
    check("pp.b0.data", bus.out_data, qb.r1);
    check("pp.b0.occupancy", 32'(occ), 1);
    step_edge();
    for (int k = 0; k < 4; k++) exp_q.push_back(word(qb, k));
    run_stream(0, 0, 1'b0, 4);
    check("pp.end.occupancy", 32'(occ), 0);

    // Nine quaternions through the two-slot FIFO under random backpressure.
    run_stream(9, 1, 1'b1, 36);
    check("wrap.drop_err", 32'(drop_err), 0);
    check("wrap.occupancy", 32'(occ), 0);

    // Fill with the sink stalled; the third quaternion must be dropped.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; drive_q(gen_q(100));
    @(negedge clk);
    check("fill.q0.in_ready", 32'(bus.in_ready), 1);
    step_edge();
    drive_q(gen_q(101));
    @(negedge clk);
    check("fill.q1.in_ready", 32'(bus.in_ready), 1);
    check("fill.q1.occupancy", 32'(occ), 1);
    step_edge();
    drive_q(gen_q(102));
    @(negedge clk);
    check("fill.q2.in_ready", 32'(bus.in_ready), 0);
    check("fill.q2.occupancy", 32'(occ), 2);
    check("fill.q2.drop_err", 32'(drop_err), 0);
    step_edge();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("fill.drop_err", 32'(drop_err), 1);
    check("fill.occupancy", 32'(occ), 2);
    check("fill.in_ready", 32'(bus.in_ready), 0);
    check("fill.head", bus.out_data, gen_q(100).r1);
    step_edge();
    for (int k = 0; k < 4; k++) exp_q.push_back(word(gen_q(100), k));
    for (int k = 0; k < 4; k++) exp_q.push_back(word(gen_q(101), k));
    run_stream(0, 0, 1'b0, 8);
    check("fill.end.occupancy", 32'(occ), 0);
    check("fill.end.drop_err", 32'(drop_err), 1);

    // Reset during the idx-2 beat with two entries held.
    bus.in_valid = 1'b1; drive_q(gen_q(300));
    step_edge();
    drive_q(gen_q(301));
    step_edge();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step_edge();
    step_edge();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid.idx", 32'(bus.out_idx), 2);
    check("rstmid.occupancy", 32'(occ), 2);
    check("rstmid.in_ready", 32'(bus.in_ready), 0);
    step_edge();
    @(negedge clk);
    check("rstmid.after.out_valid", 32'(bus.out_valid), 0);
    check("rstmid.after.occupancy", 32'(occ), 0);
    check("rstmid.after.drop_err", 32'(drop_err), 0);
    check("rstmid.after.in_ready", 32'(bus.in_ready), 0);
    step_edge();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; drive_q(gen_q(310));
    @(negedge clk);
    check("rstmid.release.in_ready", 32'(bus.in_ready), 1);
    check("rstmid.release.out_valid", 32'(bus.out_valid), 0);
    step_edge();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(word(gen_q(310), k));
    run_stream(0, 0, 1'b0, 4);
    check("rstmid.end.occupancy", 32'(occ), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
